// File: rtl/bus_requester_pkg.sv
// Shared types for the snooping MESI bus front-end.
//   NUM_CPUS     - number of requesters sharing the bus / arbiter
//   bus_op_t     - coherence command encoding driven on the bus
//   req_state_t  - bus_requester FSM states
package bus_requester_pkg;

  localparam int unsigned NUM_CPUS = 4;

  typedef enum logic [1:0] {
    BUS_RD   = 2'd0,
    BUS_RDX  = 2'd1,
    BUS_UPGR = 2'd2,
    BUS_WB   = 2'd3
  } bus_op_t;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StAddr,
    StWait,
    StDone
  } req_state_t;

  // Only reads hand a line back to the cache; upgrades and writebacks return nothing.
  function automatic logic op_returns_data(bus_op_t op);
    return (op == BUS_RD) || (op == BUS_RDX);
  endfunction

  // Only writebacks carry a data payload on the address beat.
  function automatic logic op_has_wdata(bus_op_t op);
    return op == BUS_WB;
  endfunction

endpackage

// File: rtl/bus_requester.sv
// Per-CPU bus master front-end: takes one coherence command from the cache, requests the
// bus from the round-robin arbiter, drives a single address/data beat once granted, waits
// for the acknowledgement (with a watchdog) and returns the result to the cache.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   cmd_valid/ready/op/addr/wdata - command from the cache controller (accepted in IDLE)
//   resp_valid/data/shared/err    - one-cycle completion pulse; data/flags held until next
//   req, gnt, busy                - this CPU's slice of the arbiter req/gnt/busy vectors
//   bus_valid/op/addr/wdata       - address beat driven while owning the bus
//   bus_ack, bus_rdata, bus_shared - completion from memory/snoopers
module bus_requester
  import bus_requester_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LINE_W      = 512,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  bus_op_t           cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LINE_W-1:0] cmd_wdata,
  output logic              resp_valid,
  output logic [LINE_W-1:0] resp_data,
  output logic              resp_shared,
  output logic              resp_err,
  output logic              req,
  input  logic              gnt,
  output logic              busy,
  output logic              bus_valid,
  output bus_op_t           bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [LINE_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [LINE_W-1:0] bus_rdata,
  input  logic              bus_shared
);

  localparam int unsigned     CntW    = $clog2(ACK_TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(ACK_TIMEOUT - 1);

  req_state_t        state_q, state_d;
  bus_op_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [LINE_W-1:0] resp_data_q, resp_data_d;
  logic              resp_shared_q, resp_shared_d;
  logic              resp_err_q, resp_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      op_q          <= BUS_RD;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= '0;
      resp_data_q   <= '0;
      resp_shared_q <= 1'b0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      resp_data_q   <= resp_data_d;
      resp_shared_q <= resp_shared_d;
      resp_err_q    <= resp_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cnt_d         = '0;
    resp_data_d   = resp_data_q;
    resp_shared_d = resp_shared_q;
    resp_err_d    = resp_err_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          addr_d  = cmd_addr;
          // Non-writeback ops never put data on the bus, so store zero up front.
          wdata_d = op_has_wdata(cmd_op) ? cmd_wdata : '0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (gnt) state_d = StAddr;
      end
      StAddr: begin
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        // Ack wins over a watchdog expiry landing in the same cycle.
        if (bus_ack) begin
          resp_data_d   = op_returns_data(op_q) ? bus_rdata : '0;
          resp_shared_d = bus_shared;
          resp_err_d    = 1'b0;
          cnt_d         = '0;
          state_d       = StDone;
        end else if (cnt_q == CntLast) begin
          resp_data_d   = '0;
          resp_shared_d = 1'b0;
          resp_err_d    = 1'b1;
          cnt_d         = '0;
          state_d       = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign cmd_ready   = (state_q == StIdle);
  assign req         = (state_q == StReq);
  // busy covers the whole bus tenure so the arbiter cannot grant anyone else meanwhile.
  assign busy        = (state_q == StAddr) || (state_q == StWait);
  assign bus_valid   = (state_q == StAddr);
  assign bus_op      = bus_valid ? op_q : BUS_RD;
  assign bus_addr    = bus_valid ? addr_q : '0;
  assign bus_wdata   = bus_valid ? wdata_q : '0;
  assign resp_valid  = (state_q == StDone);
  assign resp_data   = resp_data_q;
  assign resp_shared = resp_shared_q;
  assign resp_err    = resp_err_q;

endmodule

// File: doc/bus_requester.md
Name: bus_requester

Overview:
- Per-CPU bus master front-end on the snooping MESI bus. It is the requesting end of the round-robin arbiter's req/gnt/busy handshake.
- Accepts one coherence command at a time from its cache controller (BusRd, BusRdX, BusUpgr, writeback), raises req, and waits for gnt.
- Once granted, it owns the bus (busy high), drives one address/data beat, and waits for the bus acknowledgement. It then returns data and the shared flag to the cache.
- A watchdog aborts a transaction whose acknowledgement never arrives.

Parameters:
- ADDR_W, 32, physical line address width
- LINE_W, 512, cache line data width
- ACK_TIMEOUT, 64, max cycles waited in WAIT before abort (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  cache presents a command
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_op  in  bus_op_t  BUS_RD / BUS_RDX / BUS_UPGR / BUS_WB
- cmd_addr  in  ADDR_W  line address
- cmd_wdata  in  LINE_W  writeback data (BUS_WB only)
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  LINE_W  line returned by bus (valid for RD/RDX)
- resp_shared  out  1  another cache asserted shared during ack
- resp_err  out  1  completion was a timeout abort
- req  out  1  this CPU's bit of arbiter req vector
- gnt  in  1  this CPU's bit of arbiter gnt vector (combinational from arbiter)
- busy  out  1  this CPU's bit of arbiter busy vector; high while owning bus
- bus_valid  out  1  address beat strobe
- bus_op  out  bus_op_t  driven op
- bus_addr  out  ADDR_W  driven address
- bus_wdata  out  LINE_W  driven data
- bus_ack  in  1  transaction completion from memory/snoopers
- bus_rdata  in  LINE_W  returned line, valid with bus_ack
- bus_shared  in  1  shared wire, valid with bus_ack

Behaviour:
- Reset: state IDLE; req, busy, bus_valid, resp_valid, resp_err, resp_shared = 0; resp_data, bus_op, bus_addr, bus_wdata, op/addr/data registers = 0; timeout counter = 0.
- FSM states: IDLE, REQ, ADDR, WAIT, DONE.
- IDLE: cmd_ready = 1. On cmd_valid, latch op/addr/wdata and go to REQ. Command inputs are ignored in all other states.
- REQ: req = 1. Sample gnt at the clock edge; if gnt = 1, go to ADDR, otherwise stay. req is held until gnt is seen and never drops before then.
- ADDR: req = 0, busy = 1, bus_valid = 1 for exactly one cycle. bus_op/bus_addr/bus_wdata carry the latched values; bus_wdata = 0 for non-WB ops. bus_ack is ignored in this state. Always go to WAIT.
- WAIT: busy = 1; counter increments each cycle.
  - bus_ack = 1: capture bus_rdata and bus_shared (rdata forced to 0 for UPGR/WB), set resp_err = 0, go to DONE.
  - Counter reaches ACK_TIMEOUT-1 without ack: resp_err = 1, resp_data = 0, resp_shared = 0, go to DONE.
  - Ack takes priority over timeout in the same cycle.
- DONE: resp_valid = 1 for one cycle, busy = 0, counter cleared; go to IDLE.
- resp_data, resp_shared and resp_err hold their values until the next completion.
- Min latency: accept at edge 0, REQ cycle 1 (granted), ADDR cycle 2, earliest ack cycle 3, resp_valid cycle 4. Back-to-back commands are separated by one IDLE cycle.
- busy is high for every cycle of ADDR and WAIT only. This keeps the arbiter from issuing any grant while this CPU owns the bus.
- gnt seen outside REQ is ignored.
- rst asserted in any state returns the block to IDLE next edge with all outputs at reset values. The in-flight command is dropped; there is no resp_valid.

Decomposition:
- Shared package types, alongside NUM_CPUS: bus_op_t (2-bit enum: BUS_RD=0, BUS_RDX=1, BUS_UPGR=2, BUS_WB=3) and the req_state_t enum.
- Single module; the timeout counter stays inline. No sub-module is needed.
- A system wrapper instantiates NUM_CPUS copies with CPU_ID slicing into the arbiter vectors.

Test Plan:
- Uncontended RD addr 0x40: cmd at cycle 0, gnt tied to req; bus_ack at cycle 3 with rdata 0xAA..AA, shared = 1 -> bus_valid at cycle 2 only, busy cycles 2-3, resp_valid at cycle 4 with data 0xAA..AA, shared = 1, err = 0.
- Grant delayed 5 cycles, WB addr 0x80 with data 0x1234 -> req stays high 6 cycles; bus_wdata = 0x1234 on the ADDR beat; resp_data = 0.
- Two instances with arbiter, both issue RDX in the same cycle -> second is not granted while first busy = 1; it is granted the cycle after first's DONE; no overlapping bus_valid.
- UPGR with no bus_ack, ACK_TIMEOUT = 8 -> resp_valid with resp_err = 1 exactly 8 WAIT cycles after ADDR; busy drops in DONE.
- rst pulsed during WAIT -> next cycle IDLE, busy = 0, req = 0, no resp_valid; new command accepted immediately afterwards.
- bus_ack on the same cycle as timeout expiry -> resp_err = 0 and data captured.
